// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- request/status bundle between the fetch/exec control
// logic (master) and the program-counter sequencer (slave).
//   requests : advance, redirect, redirect_target, call, ret, trap, trap_pc, mret
//   status   : pc, pc_inc, epc, in_trap, ras_count, misaligned, ras_underflow
`timescale 1ns/1ps
interface pc_sequencer_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic            advance;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            call;
    logic            ret;
    logic            trap;
    logic [XLEN-1:0] trap_pc;
    logic            mret;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] epc;
    logic            in_trap;
    logic [CW-1:0]   ras_count;
    logic            misaligned;
    logic            ras_underflow;

    modport master (
        output advance, redirect, redirect_target, call, ret, trap, trap_pc, mret,
        input  pc, pc_inc, epc, in_trap, ras_count, misaligned, ras_underflow
    );

    modport slave (
        input  advance, redirect, redirect_target, call, ret, trap, trap_pc, mret,
        output pc, pc_inc, epc, in_trap, ras_count, misaligned, ras_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter with return-address stack and trap entry/exit.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : pc_sequencer_if.slave (requests in, pc/epc/RAS status out)
// One action per cycle, priority trap > mret(in trap) > redirect > ret > advance.
`timescale 1ns/1ps
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int unsigned AW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    typedef enum logic [2:0] {
        ACT_HOLD, ACT_ADV, ACT_RET, ACT_REDIR, ACT_MRET, ACT_TRAP
    } act_t;

    act_t            act;
    logic [XLEN-1:0] pc, epc, pc_inc;
    logic            in_trap, misaligned, ras_underflow;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr;   // next free slot; top of stack is wr_ptr-1
    logic [AW-1:0]   top_ptr;
    logic [XLEN-1:0] ras [RAS_DEPTH];

    logic            ras_we;
    logic [AW-1:0]   ras_waddr;
    logic            replace_top;

    assign pc_inc  = pc + XLEN'(4);
    assign top_ptr = wr_ptr - AW'(1);

    always_comb begin
        act = ACT_HOLD;
        if (bus.trap)                 act = ACT_TRAP;
        else if (bus.mret && in_trap) act = ACT_MRET;
        else if (bus.redirect)        act = ACT_REDIR;
        else if (bus.ret)             act = ACT_RET;
        else if (bus.advance)         act = ACT_ADV;
    end

    // call+ret on a redirect rewrites the top in place; an empty stack
    // has no top, so it degrades to an ordinary push.
    always_comb begin
        replace_top = bus.ret && (count != '0);
        ras_we      = (act == ACT_REDIR) && bus.call;
        ras_waddr   = replace_top ? top_ptr : wr_ptr;
    end

    // Stack storage carries no reset: count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset && ras_we)
            ras[ras_waddr] <= pc_inc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_VECTOR;
            epc           <= '0;
            in_trap       <= 1'b0;
            count         <= '0;
            wr_ptr        <= '0;
            misaligned    <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            misaligned    <= 1'b0;
            ras_underflow <= 1'b0;
            case (act)
                ACT_TRAP: begin
                    pc      <= TRAP_VECTOR;
                    epc     <= bus.trap_pc;
                    in_trap <= 1'b1;
                end
                ACT_MRET: begin
                    pc      <= epc;
                    in_trap <= 1'b0;
                end
                ACT_REDIR: begin
                    pc         <= {bus.redirect_target[XLEN-1:2], 2'b00};
                    misaligned <= |bus.redirect_target[1:0];
                    // Pushing into a full stack wraps over the oldest entry.
                    if (bus.call && !replace_top) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (count != FULL) count <= count + CW'(1);
                    end
                end
                ACT_RET: begin
                    if (count != '0) begin
                        pc     <= ras[top_ptr];
                        wr_ptr <= top_ptr;
                        count  <= count - CW'(1);
                    end else begin
                        pc            <= pc_inc;
                        ras_underflow <= 1'b1;
                    end
                end
                ACT_ADV: pc <= pc_inc;
                default: ;
            endcase
        end
    end

    assign bus.pc            = pc;
    assign bus.pc_inc        = pc_inc;
    assign bus.epc           = epc;
    assign bus.in_trap       = in_trap;
    assign bus.ras_count     = count;
    assign bus.misaligned    = misaligned;
    assign bus.ras_underflow = ras_underflow;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width in bits (>=8).
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 'h100, PC value loaded on trap.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port advance  input  1  current pc consumed by fetch; step to pc_inc.
REQ-008 SHALL have port redirect  input  1  branch/jump taken; load redirect_target.
REQ-009 SHALL have port redirect_target  input  XLEN  jump target address.
REQ-010 SHALL have port call  input  1  qualifies redirect as a call; push return address.
REQ-011 SHALL have port ret  input  1  return; load RAS top and pop.
REQ-012 SHALL have port trap  input  1  exception entry.
REQ-013 SHALL have port trap_pc  input  XLEN  address of faulting instruction.
REQ-014 SHALL have port mret  input  1  exception return.
REQ-015 SHALL have port pc  output  XLEN  current fetch address, registered.
REQ-016 SHALL have port pc_inc  output  XLEN  combinational pc + 4, modulo 2^XLEN.
REQ-017 SHALL have port epc  output  XLEN  saved exception PC, registered.
REQ-018 SHALL have port in_trap  output  1  handler active, registered.
REQ-019 SHALL have port ras_count  output  clog2(RAS_DEPTH)+1  valid RAS entries.
REQ-020 SHALL have port misaligned  output  1  one-cycle pulse: last redirect target had bits[1:0]!=0.
REQ-021 SHALL have port ras_underflow  output  1  one-cycle pulse: ret with empty RAS.

Function
REQ-022 SHALL apply exactly one action per cycle, priority: trap > mret > redirect (incl. call) > ret > advance > hold.
REQ-023 Trap SHALL set pc<=TRAP_VECTOR, epc<=trap_pc, in_trap<=1; nested trap overwrites epc.
REQ-024 mret with in_trap=1 SHALL set pc<=epc, in_trap<=0; with in_trap=0 SHALL be ignored and fall through to lower priorities.
REQ-025 Redirect SHALL set pc<={redirect_target[XLEN-1:2],2'b00}; misaligned pulses next cycle iff redirect_target[1:0]!=0.
REQ-026 redirect&call SHALL additionally push pc_inc; call without redirect SHALL be ignored.
REQ-027 Push when full SHALL overwrite the oldest entry (circular); ras_count saturates at RAS_DEPTH.
REQ-028 ret (winning priority) with ras_count>0 SHALL set pc<=top entry and decrement ras_count.
REQ-029 ret with ras_count=0 SHALL set pc<=pc_inc and pulse ras_underflow next cycle; RAS unchanged.
REQ-030 redirect&call&ret together SHALL load redirect_target and replace top with pc_inc, ras_count unchanged (push if empty).
REQ-031 advance SHALL set pc<=pc_inc, wrapping from 2^XLEN-4 to 0.
REQ-032 With no action, all state SHALL hold.
REQ-033 trap and mret SHALL NOT modify the RAS; misaligned/ras_underflow SHALL be 0 in all other cycles.

Reset
REQ-034 reset SHALL override all inputs: pc<=RESET_VECTOR, epc<=0, in_trap<=0, ras_count<=0, misaligned<=0, ras_underflow<=0.
REQ-035 Reset mid-operation SHALL discard RAS contents; stored entries need not be cleared.

Verification
REQ-036 Reset, then advance x3 -> pc 0, 4, 8, 12; pc_inc=pc+4 each cycle.
REQ-037 pc='hFFFFFFFC, advance -> pc=0.
REQ-038 redirect+call to 'h200 at pc='h10, then ret -> pc='h200, then 'h14; ras_count 1 then 0.
REQ-039 RAS_DEPTH=4: 5 calls returning 'h4,'h8,'hC,'h10,'h14, then 5 rets -> pcs 'h14,'h10,'hC,'h8, then pc_inc with ras_underflow=1.
REQ-040 trap (trap_pc='h40) with redirect asserted -> pc='h100, epc='h40, in_trap=1; mret -> pc='h40, in_trap=0.
REQ-041 redirect to 'h203 -> pc='h200, misaligned=1 one cycle; reset during same cycle -> pc=RESET_VECTOR, misaligned=0.
